// File: rtl/i2c_fifo_pkg.sv
// Shared types and constants for the I2C master TX FIFO read side.
// State encodings and output buffer geometry.
package i2c_fifo_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE_ENC,
        ST_RUN  = RUN_ENC,
        ST_DONE = DONE_ENC
    } rd_state_t;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_CW    = $clog2(BUF_DEPTH + 1);

    localparam logic [BUF_CW-1:0] BUF_FULL = BUF_CW'(BUF_DEPTH);

endpackage

// File: rtl/i2c_tx_fifo_read_ctrl_if.sv
// Bundle of FIFO, byte-shifter and master-FSM signals of the read controller.
// master = the controller itself, slave = its surroundings.
interface i2c_tx_fifo_read_ctrl_if #(
    parameter int data_width  = 8,
    parameter int count_width = 8
);

    logic                   start_i;
    logic                   abort_i;
    logic [count_width-1:0] byte_count_i;
    logic                   fifo_empty_i;
    logic [data_width-1:0]  fifo_read_data_i;
    logic                   fifo_read_inc_o;
    logic [data_width-1:0]  byte_data_o;
    logic                   byte_valid_o;
    logic                   byte_ready_i;
    logic                   byte_last_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   aborted_o;
    logic                   underrun_o;
    logic [count_width-1:0] remaining_o;

    modport master (
        input  start_i,
        input  abort_i,
        input  byte_count_i,
        input  fifo_empty_i,
        input  fifo_read_data_i,
        output fifo_read_inc_o,
        output byte_data_o,
        output byte_valid_o,
        input  byte_ready_i,
        output byte_last_o,
        output busy_o,
        output done_o,
        output aborted_o,
        output underrun_o,
        output remaining_o
    );

    modport slave (
        output start_i,
        output abort_i,
        output byte_count_i,
        output fifo_empty_i,
        output fifo_read_data_i,
        input  fifo_read_inc_o,
        input  byte_data_o,
        input  byte_valid_o,
        output byte_ready_i,
        input  byte_last_o,
        input  busy_o,
        input  done_o,
        input  aborted_o,
        input  underrun_o,
        input  remaining_o
    );

endinterface

// File: rtl/i2c_byte_skid_buffer.sv
// Two-entry FIFO-ordered register buffer between the TX FIFO and the shifter.
// Push and pop in the same cycle keep the fill level, so throughput is 1 byte/cycle.
module i2c_byte_skid_buffer
    import i2c_fifo_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [data_width-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [BUF_CW-1:0]     cnt_o,
    output logic [data_width-1:0] head_o
);

    logic [data_width-1:0] r_mem0;
    logic [data_width-1:0] r_mem1;
    logic [BUF_CW-1:0]     r_cnt;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_wr_hi;

    assign w_pop   = pop_i && (r_cnt != '0);
    assign w_push  = push_i && (w_pop || (r_cnt != BUF_FULL));
    // slot after the (possibly shifted) last valid entry
    assign w_wr_hi = w_pop ? (r_cnt == BUF_FULL) : (r_cnt != '0);

    assign cnt_o  = r_cnt;
    assign head_o = r_mem0;

    // shift-on-pop storage and fill level
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_cnt  <= '0;
        end else if (flush_i) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_mem0 <= r_mem1;
            end
            if (w_push) begin
                if (w_wr_hi) begin
                    r_mem1 <= push_data_i;
                end else begin
                    r_mem0 <= push_data_i;
                end
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + BUF_CW'(1);
                2'b01:   r_cnt <= r_cnt - BUF_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/i2c_tx_fifo_read_ctrl.sv
// Read-side sequencer of the I2C master TX FIFO for one transfer.
// Pops exactly byte_count_i bytes and hands them to the shifter via valid/ready.
module i2c_tx_fifo_read_ctrl
    import i2c_fifo_pkg::*;
#(
    parameter int data_width  = 8,
    parameter int count_width = 8
) (
    input logic                     read_clock_i,
    input logic                     read_reset_n_i,
    i2c_tx_fifo_read_ctrl_if.master bus
);

    localparam logic [count_width-1:0] CNT_ONE = count_width'(1);

    rd_state_t              r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_aborted;
    logic                   r_underrun;
    logic [count_width-1:0] r_fetch_cnt;
    logic [count_width-1:0] r_send_cnt;

    logic [BUF_CW-1:0]      w_buf_cnt;
    logic [data_width-1:0]  w_head;
    logic                   w_valid;
    logic                   w_run;
    logic                   w_start;
    logic                   w_abort;
    logic                   w_pop;
    logic                   w_hs;

    assign w_run   = (r_state == ST_RUN);
    assign w_start = (r_state == ST_IDLE) && bus.start_i && !bus.abort_i;
    assign w_abort = (r_state != ST_IDLE) && bus.abort_i;
    assign w_valid = (w_buf_cnt != '0);

    assign w_pop = w_run && (r_fetch_cnt != '0) && !bus.fifo_empty_i
                   && (w_buf_cnt != BUF_FULL) && !bus.abort_i;
    assign w_hs  = w_run && w_valid && bus.byte_ready_i && !bus.abort_i;

    i2c_byte_skid_buffer #(
        .data_width (data_width)
    ) u_buf (
        .clk_i       (read_clock_i),
        .rst_n_i     (read_reset_n_i),
        .push_i      (w_pop),
        .push_data_i (bus.fifo_read_data_i),
        .pop_i       (w_hs),
        .flush_i     (w_abort),
        .cnt_o       (w_buf_cnt),
        .head_o      (w_head)
    );

    assign bus.fifo_read_inc_o = w_pop;
    assign bus.byte_data_o     = w_head;
    assign bus.byte_valid_o    = w_valid;
    assign bus.byte_last_o     = w_valid && (r_send_cnt == CNT_ONE);
    assign bus.busy_o          = r_busy;
    assign bus.done_o          = r_done;
    assign bus.aborted_o       = r_aborted;
    assign bus.underrun_o      = r_underrun;
    assign bus.remaining_o     = r_send_cnt;

    // transfer FSM with registered busy/done/aborted
    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (bus.byte_count_i == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort_i) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (w_hs && (r_send_cnt == CNT_ONE)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.abort_i) begin
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // fetch/send counters and starvation flag
    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            r_fetch_cnt <= '0;
            r_send_cnt  <= '0;
            r_underrun  <= 1'b0;
        end else begin
            if (w_abort) begin
                r_fetch_cnt <= '0;
                r_send_cnt  <= '0;
            end else if (w_start) begin
                r_fetch_cnt <= bus.byte_count_i;
                r_send_cnt  <= bus.byte_count_i;
            end else begin
                if (w_pop) begin
                    r_fetch_cnt <= r_fetch_cnt - CNT_ONE;
                end
                if (w_hs) begin
                    r_send_cnt <= r_send_cnt - CNT_ONE;
                end
            end
            r_underrun <= w_run && !bus.abort_i && (r_fetch_cnt != '0)
                          && (w_buf_cnt == '0) && bus.fifo_empty_i;
        end
    end

endmodule

// File: tb/tb_i2c_tx_fifo_read_ctrl.sv
// Directed bench for i2c_tx_fifo_read_ctrl with a small FIFO model.
// Inputs change and outputs are sampled 1-3 time units after the rising edge.
module tb_i2c_tx_fifo_read_ctrl;

    logic clk;
    logic rst_n;

    i2c_tx_fifo_read_ctrl_if #(
        .data_width  (8),
        .count_width (8)
    ) bus ();

    i2c_tx_fifo_read_ctrl #(
        .data_width  (8),
        .count_width (8)
    ) dut (
        .read_clock_i   (clk),
        .read_reset_n_i (rst_n),
        .bus            (bus)
    );

    logic [7:0] mem [16];
    logic [3:0] rd_ptr;
    logic [3:0] wr_ptr;
    logic       fifo_clr;
    int         pops;
    int         p0;
    int         total;
    int         bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.fifo_empty_i     = (rd_ptr == wr_ptr);
    assign bus.fifo_read_data_i = mem[rd_ptr];

    // FIFO read pointer and pop counter
    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
            pops   <= 0;
        end else if (bus.fifo_read_inc_o) begin
            rd_ptr <= rd_ptr + 4'd1;
            pops   <= pops + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 4'd1;
    endtask

    task automatic clear_fifo();
        fifo_clr = 1'b1;
        cyc();
        fifo_clr = 1'b0;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        wr_ptr           = 4'd0;
        fifo_clr         = 1'b1;
        bus.start_i      = 1'b0;
        bus.abort_i      = 1'b0;
        bus.byte_count_i = 8'd0;
        bus.byte_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        cyc();
        cyc();
        fifo_clr = 1'b0;

        // reset state
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_abrt", 32'(bus.aborted_o), 0);
        chk("rst_undr", 32'(bus.underrun_o), 0);
        chk("rst_valid", 32'(bus.byte_valid_o), 0);
        chk("rst_last", 32'(bus.byte_last_o), 0);
        chk("rst_data", 32'(bus.byte_data_o), 0);
        chk("rst_rem", 32'(bus.remaining_o), 0);
        chk("rst_inc", 32'(bus.fifo_read_inc_o), 0);
        rst_n = 1'b1;
        cyc();

        // 1: normal 4-byte run
        for (int i = 0; i < 4; i++) push_byte(8'(8'hA1 + i));
        p0               = pops;
        bus.byte_ready_i = 1'b1;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd4;
        cyc();
        bus.start_i      = 1'b0;
        bus.byte_count_i = 8'd0;
        #1;
        chk("t1_busy", 32'(bus.busy_o), 1);
        chk("t1_pop0", 32'(bus.fifo_read_inc_o), 1);
        chk("t1_nvalid", 32'(bus.byte_valid_o), 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", 32'(bus.byte_data_o), 32'hA1 + 32'(i));
            chk("t1_valid", 32'(bus.byte_valid_o), 1);
            chk("t1_last", 32'(bus.byte_last_o), 32'(i == 3));
            chk("t1_rem", 32'(bus.remaining_o), 32'(4 - i));
            cyc();
        end
        chk("t1_done", 32'(bus.done_o), 1);
        chk("t1_abrt", 32'(bus.aborted_o), 0);
        chk("t1_busy0", 32'(bus.busy_o), 0);
        chk("t1_pops", 32'(pops - p0), 4);
        cyc();
        chk("t1_done0", 32'(bus.done_o), 0);

        // 2: backpressure
        for (int i = 0; i < 3; i++) push_byte(8'(8'hB1 + i));
        p0               = pops;
        bus.byte_ready_i = 1'b0;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd3;
        cyc();
        bus.start_i = 1'b0;
        repeat (5) cyc();
        #1;
        chk("t2_inc", 32'(bus.fifo_read_inc_o), 0);
        chk("t2_pops", 32'(pops - p0), 2);
        chk("t2_head", 32'(bus.byte_data_o), 32'hB1);
        chk("t2_rem", 32'(bus.remaining_o), 3);
        bus.byte_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_data", 32'(bus.byte_data_o), 32'hB1 + 32'(i));
            chk("t2_last", 32'(bus.byte_last_o), 32'(i == 2));
            cyc();
        end
        chk("t2_done", 32'(bus.done_o), 1);
        chk("t2_pops3", 32'(pops - p0), 3);
        cyc();

        // 3: underrun
        push_byte(8'hC1);
        p0               = pops;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd3;
        cyc();
        bus.start_i = 1'b0;
        cyc();
        chk("t3_head", 32'(bus.byte_data_o), 32'hC1);
        chk("t3_undr0", 32'(bus.underrun_o), 0);
        cyc();
        chk("t3_nvalid", 32'(bus.byte_valid_o), 0);
        chk("t3_rem2", 32'(bus.remaining_o), 2);
        cyc();
        chk("t3_undr1", 32'(bus.underrun_o), 1);
        repeat (7) cyc();
        chk("t3_undr_hold", 32'(bus.underrun_o), 1);
        chk("t3_busy", 32'(bus.busy_o), 1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        cyc();
        chk("t3_undr_clr", 32'(bus.underrun_o), 0);
        chk("t3_data2", 32'(bus.byte_data_o), 32'hC2);
        chk("t3_valid2", 32'(bus.byte_valid_o), 1);
        cyc();
        chk("t3_data3", 32'(bus.byte_data_o), 32'hC3);
        chk("t3_last", 32'(bus.byte_last_o), 1);
        cyc();
        chk("t3_done", 32'(bus.done_o), 1);
        chk("t3_pops", 32'(pops - p0), 3);
        cyc();

        // 4: abort after two handshakes
        for (int i = 0; i < 5; i++) push_byte(8'(8'hD1 + i));
        p0               = pops;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd5;
        cyc();
        bus.start_i = 1'b0;
        cyc();
        chk("t4_d1", 32'(bus.byte_data_o), 32'hD1);
        cyc();
        chk("t4_d2", 32'(bus.byte_data_o), 32'hD2);
        cyc();
        chk("t4_d3", 32'(bus.byte_data_o), 32'hD3);
        chk("t4_rem3", 32'(bus.remaining_o), 3);
        bus.abort_i = 1'b1;
        #1;
        chk("t4_nopop", 32'(bus.fifo_read_inc_o), 0);
        cyc();
        bus.abort_i = 1'b0;
        chk("t4_done", 32'(bus.done_o), 1);
        chk("t4_abrt", 32'(bus.aborted_o), 1);
        chk("t4_busy", 32'(bus.busy_o), 0);
        chk("t4_valid", 32'(bus.byte_valid_o), 0);
        chk("t4_rem0", 32'(bus.remaining_o), 0);
        chk("t4_pops", 32'(pops - p0), 3);
        chk("t4_left", 32'(4'(wr_ptr - rd_ptr)), 2);
        cyc();
        chk("t4_done0", 32'(bus.done_o), 0);
        chk("t4_abrt0", 32'(bus.aborted_o), 0);
        repeat (3) begin
            cyc();
            chk("t4_idle_inc", 32'(bus.fifo_read_inc_o), 0);
        end
        chk("t4_pops_end", 32'(pops - p0), 3);
        clear_fifo();

        // 5a: zero-length start
        push_byte(8'hE1);
        p0               = pops;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd0;
        cyc();
        bus.start_i = 1'b0;
        chk("t5a_done", 32'(bus.done_o), 1);
        chk("t5a_abrt", 32'(bus.aborted_o), 0);
        chk("t5a_busy", 32'(bus.busy_o), 0);
        cyc();
        chk("t5a_done0", 32'(bus.done_o), 0);
        chk("t5a_pops", 32'(pops - p0), 0);

        // 5b: start while busy is ignored
        bus.byte_ready_i = 1'b0;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd1;
        cyc();
        bus.start_i = 1'b0;
        cyc();
        chk("t5b_data", 32'(bus.byte_data_o), 32'hE1);
        chk("t5b_rem", 32'(bus.remaining_o), 1);
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd5;
        cyc();
        bus.start_i = 1'b0;
        chk("t5b_rem_keep", 32'(bus.remaining_o), 1);
        chk("t5b_busy", 32'(bus.busy_o), 1);
        bus.byte_ready_i = 1'b1;
        cyc();
        chk("t5b_done", 32'(bus.done_o), 1);
        chk("t5b_pops", 32'(pops - p0), 1);
        cyc();

        // 5c: start and abort together in IDLE
        push_byte(8'h5C);
        p0               = pops;
        bus.start_i      = 1'b1;
        bus.abort_i      = 1'b1;
        bus.byte_count_i = 8'd2;
        cyc();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("t5c_busy", 32'(bus.busy_o), 0);
        chk("t5c_done", 32'(bus.done_o), 0);
        chk("t5c_abrt", 32'(bus.aborted_o), 0);
        cyc();
        chk("t5c_busy2", 32'(bus.busy_o), 0);
        chk("t5c_pops", 32'(pops - p0), 0);
        clear_fifo();

        // 6: async reset mid-transfer
        for (int i = 0; i < 3; i++) push_byte(8'(8'hF1 + i));
        bus.byte_ready_i = 1'b0;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd3;
        cyc();
        bus.start_i = 1'b0;
        cyc();
        cyc();
        chk("t6_pre_valid", 32'(bus.byte_valid_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(bus.busy_o), 0);
        chk("t6_valid", 32'(bus.byte_valid_o), 0);
        chk("t6_data", 32'(bus.byte_data_o), 0);
        chk("t6_last", 32'(bus.byte_last_o), 0);
        chk("t6_rem", 32'(bus.remaining_o), 0);
        chk("t6_inc", 32'(bus.fifo_read_inc_o), 0);
        chk("t6_done", 32'(bus.done_o), 0);
        chk("t6_undr", 32'(bus.underrun_o), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (3) begin
            cyc();
            chk("t6_nodone", 32'(bus.done_o), 0);
            chk("t6_idle", 32'(bus.busy_o), 0);
        end
        clear_fifo();
        push_byte(8'h6B);
        p0               = pops;
        bus.byte_ready_i = 1'b1;
        bus.start_i      = 1'b1;
        bus.byte_count_i = 8'd1;
        cyc();
        bus.start_i = 1'b0;
        cyc();
        chk("t6_n_data", 32'(bus.byte_data_o), 32'h6B);
        chk("t6_n_last", 32'(bus.byte_last_o), 1);
        chk("t6_n_rem", 32'(bus.remaining_o), 1);
        cyc();
        chk("t6_n_done", 32'(bus.done_o), 1);
        chk("t6_n_abrt", 32'(bus.aborted_o), 0);
        chk("t6_n_pops", 32'(pops - p0), 1);
        cyc();
        chk("t6_n_done0", 32'(bus.done_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
